// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, palette indices/colours and bus types.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned FRAME_PIXELS = H_VISIBLE * V_VISIBLE;

    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned CHAN_W  = 8;

    localparam logic [COLOR_W-1:0] IDX_BOUNDARY = COLOR_W'(0);
    localparam logic [COLOR_W-1:0] IDX_SNAKE    = COLOR_W'(1);
    localparam logic [COLOR_W-1:0] IDX_GAMEOVER = COLOR_W'(2);
    localparam logic [COLOR_W-1:0] IDX_APPLE    = COLOR_W'(3);
    localparam logic [COLOR_W-1:0] IDX_BG       = COLOR_W'(4);

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE    = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};
    localparam rgb_t  RGB_BLACK    = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t  RGB_SNAKE    = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam rgb_t  RGB_GAMEOVER = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t  RGB_APPLE    = '{r: 8'hFF, g: 8'h40, b: 8'h40};
    localparam rgb_t  RGB_BG       = '{r: 8'h20, g: 8'h20, b: 8'h20};

endpackage

// File: rtl/vga_sync_timer.sv
// Horizontal/vertical pixel counters decoding raw (undelayed) HS, VS and BLANK_n.
module vga_sync_timer
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS = H_VISIBLE,
    parameter int unsigned H_FP  = H_FRONT,
    parameter int unsigned H_SP  = H_SYNC,
    parameter int unsigned H_BP  = H_BACK,
    parameter int unsigned V_VIS = V_VISIBLE,
    parameter int unsigned V_FP  = V_FRONT,
    parameter int unsigned V_SP  = V_SYNC,
    parameter int unsigned V_BP  = V_BACK
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    output sync_t raw_sync_c_o
);

    localparam int unsigned H_TOT    = H_VIS + H_FP + H_SP + H_BP;
    localparam int unsigned V_TOT    = V_VIS + V_FP + V_SP + V_BP;
    localparam int unsigned HW       = $clog2(H_TOT);
    localparam int unsigned VW       = $clog2(V_TOT);
    localparam int unsigned H_ACT_LO = H_SP + H_BP;
    localparam int unsigned H_ACT_HI = H_ACT_LO + H_VIS;
    localparam int unsigned V_ACT_LO = V_SP + V_BP;
    localparam int unsigned V_ACT_HI = V_ACT_LO + V_VIS;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    // Line counter wraps at H_TOT; frame counter advances on each line wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HW'(H_TOT - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == VW'(V_TOT - 1)) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Sync pulses sit at the start of each line/frame, followed by back porch then video.
    always_comb begin
        raw_sync_c_o.hs      = (h_cnt_q >= HW'(H_SP));
        raw_sync_c_o.vs      = (v_cnt_q >= VW'(V_SP));
        raw_sync_c_o.blank_n = (h_cnt_q >= HW'(H_ACT_LO)) && (h_cnt_q < HW'(H_ACT_HI)) &&
                               (v_cnt_q >= VW'(V_ACT_LO)) && (v_cnt_q < VW'(V_ACT_HI));
    end

endmodule

// File: rtl/vga_video_core.sv
// VGA timing core: pixel address generation, 2-stage palette pipeline and sync delay matched to it.
module vga_video_core
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS = H_VISIBLE,
    parameter int unsigned H_FP  = H_FRONT,
    parameter int unsigned H_SP  = H_SYNC,
    parameter int unsigned H_BP  = H_BACK,
    parameter int unsigned V_VIS = V_VISIBLE,
    parameter int unsigned V_FP  = V_FRONT,
    parameter int unsigned V_SP  = V_SYNC,
    parameter int unsigned V_BP  = V_BACK
) (
    input  logic                iVGA_CLK,
    input  logic                iRST_n,
    input  logic [COLOR_W-1:0]  color_index,
    output logic [ADDR_W-1:0]   oADDR,
    output logic                oHS,
    output logic                oVS,
    output logic                oBLANK_n,
    output logic [CHAN_W-1:0]   r_data,
    output logic [CHAN_W-1:0]   g_data,
    output logic [CHAN_W-1:0]   b_data
);

    sync_t              raw_c;
    sync_t              sync_d1_q;
    sync_t              sync_q;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOR_W-1:0] idx_q;
    rgb_t               pal_c;
    rgb_t               rgb_q, rgb_d;

    vga_sync_timer #(
        .H_VIS (H_VIS), .H_FP (H_FP), .H_SP (H_SP), .H_BP (H_BP),
        .V_VIS (V_VIS), .V_FP (V_FP), .V_SP (V_SP), .V_BP (V_BP)
    ) u_timer (
        .clk_i        (iVGA_CLK),
        .rst_n_i      (iRST_n),
        .raw_sync_c_o (raw_c)
    );

    // Address clears in the hsync/vsync overlap and counts only visible pixels.
    always_comb begin
        addr_d = addr_q;
        if (!raw_c.hs && !raw_c.vs) begin
            addr_d = '0;
        end else if (raw_c.blank_n) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        pal_c = RGB_BLACK;
        case (idx_q)
            IDX_BOUNDARY: pal_c = RGB_BLACK;
            IDX_SNAKE:    pal_c = RGB_SNAKE;
            IDX_GAMEOVER: pal_c = RGB_GAMEOVER;
            IDX_APPLE:    pal_c = RGB_APPLE;
            IDX_BG:       pal_c = RGB_BG;
            default:      pal_c = RGB_BLACK;
        endcase
    end

    // Blank gating uses the sync stage that moves into the output register with this colour.
    always_comb begin
        rgb_d = RGB_BLACK;
        if (sync_d1_q.blank_n) begin
            rgb_d = pal_c;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            addr_q    <= '0;
            idx_q     <= '0;
            rgb_q     <= RGB_BLACK;
            sync_d1_q <= SYNC_IDLE;
            sync_q    <= SYNC_IDLE;
        end else begin
            addr_q    <= addr_d;
            idx_q     <= color_index;
            rgb_q     <= rgb_d;
            sync_d1_q <= raw_c;
            sync_q    <= sync_d1_q;
        end
    end

    assign oADDR    = addr_q;
    assign oHS      = sync_q.hs;
    assign oVS      = sync_q.vs;
    assign oBLANK_n = sync_q.blank_n;
    assign r_data   = rgb_q.r;
    assign g_data   = rgb_q.g;
    assign b_data   = rgb_q.b;

endmodule

// File: tb/tb_vga_video_core.sv
// Self-checking bench: full-size core plus a vertically shortened core for whole-frame checks.
module tb_vga_video_core;

    localparam int HT       = 800;
    localparam int HS_W     = 96;
    localparam int H_START  = 144;
    localparam int HV       = 640;
    localparam int F_VT     = 525;
    localparam int F_VSTART = 35;
    localparam int F_VV     = 480;
    localparam int S_VT     = 13;
    localparam int S_VSTART = 5;
    localparam int S_VV     = 6;
    localparam int S_FRAME  = HT * S_VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  color_index = 8'd0;

    logic [18:0] f_addr, s_addr;
    logic        f_hs, f_vs, f_blank, s_hs, s_vs, s_blank;
    logic [7:0]  f_r, f_g, f_b, s_r, s_g, s_b;

    int          errors = 0;
    int          checks = 0;
    int          n = 0;
    logic [7:0]  ci_hist [4];

    always #5 clk = ~clk;

    vga_video_core dut_f (
        .iVGA_CLK (clk), .iRST_n (rst_n), .color_index (color_index),
        .oADDR (f_addr), .oHS (f_hs), .oVS (f_vs), .oBLANK_n (f_blank),
        .r_data (f_r), .g_data (f_g), .b_data (f_b)
    );

    vga_video_core #(.V_VIS(6), .V_FP(2), .V_SP(2), .V_BP(3)) dut_s (
        .iVGA_CLK (clk), .iRST_n (rst_n), .color_index (color_index),
        .oADDR (s_addr), .oHS (s_hs), .oVS (s_vs), .oBLANK_n (s_blank),
        .r_data (s_r), .g_data (s_g), .b_data (s_b)
    );

    // ---------------- reference model (p = clocks since reset release) ----------------
    function automatic bit m_hs(input int p);
        return (p % HT) >= HS_W;
    endfunction

    function automatic bit m_vs(input int p, input int vt);
        return ((p / HT) % vt) >= 2;
    endfunction

    function automatic bit m_blank(input int p, input int vt, input int vstart, input int vv);
        int h;
        int v;
        h = p % HT;
        v = (p / HT) % vt;
        return (h >= H_START) && (h < H_START + HV) && (v >= vstart) && (v < vstart + vv);
    endfunction

    function automatic logic [2:0] e_sync(input int p, input int vt, input int vstart, input int vv);
        if (p < 2) return 3'b110;
        return {m_hs(p - 2), m_vs(p - 2, vt), m_blank(p - 2, vt, vstart, vv)};
    endfunction

    // Visible pixels already passed in the current frame; frame end holds the full count until wrap.
    function automatic int m_addr(input int p, input int vt, input int vstart, input int vv);
        int h;
        int v;
        int lines;
        int inl;
        h = p % HT;
        v = (p / HT) % vt;
        if (h == 0 && v == 0 && p > 0) return vv * HV;
        lines = v - vstart;
        if (lines < 0) lines = 0;
        if (lines > vv) lines = vv;
        inl = 0;
        if (v >= vstart && v < vstart + vv) begin
            inl = h - H_START;
            if (inl < 0) inl = 0;
            if (inl > HV) inl = HV;
        end
        return lines * HV + inl;
    endfunction

    function automatic logic [23:0] m_pal(input logic [7:0] idx);
        case (idx)
            8'd1:    return 24'h00FF00;
            8'd2:    return 24'hFF0000;
            8'd3:    return 24'hFF4040;
            8'd4:    return 24'h202020;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] e_rgb(input int p, input int vt, input int vstart, input int vv);
        if (p < 2) return 24'h0;
        if (!m_blank(p - 2, vt, vstart, vv)) return 24'h0;
        return m_pal(ci_hist[2'(p - 2)]);
    endfunction

    function automatic logic [7:0] rand_ci();
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return 8'($urandom_range(0, 7));
    endfunction

    // Drive the index for the current clock, advance one edge, sample 1 time unit later.
    task automatic tick(input logic [7:0] ci);
        color_index = ci;
        ci_hist[2'(n)] = ci;
        @(posedge clk);
        #1;
        n++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        color_index = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({f_hs, f_vs, f_blank} !== 3'b110) begin
            errors++; $display("FAIL reset_sync_f got=%b exp=110", {f_hs, f_vs, f_blank});
        end
        checks++;
        if ({s_hs, s_vs, s_blank} !== 3'b110) begin
            errors++; $display("FAIL reset_sync_s got=%b exp=110", {s_hs, s_vs, s_blank});
        end
        checks++;
        if (f_addr !== 19'd0) begin
            errors++; $display("FAIL reset_addr got=%0d exp=0", f_addr);
        end
        checks++;
        if ({f_r, f_g, f_b} !== 24'h0) begin
            errors++; $display("FAIL reset_rgb got=%06h exp=000000", {f_r, f_g, f_b});
        end
        #2;
        rst_n = 1'b1;
        n = 0;
        #1;
        checks++;
        if ({f_hs, f_vs, f_blank} !== 3'b110) begin
            errors++; $display("FAIL release_sync got=%b exp=110", {f_hs, f_vs, f_blank});
        end
    endtask

    // Two short frames cycle-by-cycle against the model, plus direct period/width measurements.
    task automatic test_frame_timing();
        logic       p_fhs = 1'b1, p_fvs = 1'b1, p_svs = 1'b1, p_sbl = 1'b0;
        int         fhs_fall = -1, fvs_fall = -1, svs_fall = -1, sbl_rise = -1;
        int         sbl_count = 0;
        while (n < 2 * S_FRAME + 100) begin
            tick(rand_ci());
            checks++;
            if ({f_hs, f_vs, f_blank} !== e_sync(n, F_VT, F_VSTART, F_VV)) begin
                errors++; $display("FAIL sync_f n=%0d got=%b exp=%b", n, {f_hs, f_vs, f_blank}, e_sync(n, F_VT, F_VSTART, F_VV));
            end
            checks++;
            if ({s_hs, s_vs, s_blank} !== e_sync(n, S_VT, S_VSTART, S_VV)) begin
                errors++; $display("FAIL sync_s n=%0d got=%b exp=%b", n, {s_hs, s_vs, s_blank}, e_sync(n, S_VT, S_VSTART, S_VV));
            end
            checks++;
            if (s_addr !== 19'(m_addr(n, S_VT, S_VSTART, S_VV))) begin
                errors++; $display("FAIL addr_s n=%0d got=%0d exp=%0d", n, s_addr, m_addr(n, S_VT, S_VSTART, S_VV));
            end
            checks++;
            if ({s_r, s_g, s_b} !== e_rgb(n, S_VT, S_VSTART, S_VV)) begin
                errors++; $display("FAIL rgb_s n=%0d got=%06h exp=%06h", n, {s_r, s_g, s_b}, e_rgb(n, S_VT, S_VSTART, S_VV));
            end
            // Frame-edge address landmarks of the short core.
            if (n == 10 * HT + 783 || n == 10 * HT + 784 || n == S_FRAME || n == S_FRAME + 1) begin
                checks++;
                if (s_addr !== ((n == 10 * HT + 783) ? 19'd3839 : (n == S_FRAME + 1) ? 19'd0 : 19'd3840)) begin
                    errors++; $display("FAIL addr_landmark n=%0d got=%0d", n, s_addr);
                end
            end
            // HSYNC: first fall 2 clocks after release, period 800, low 96.
            if (p_fhs && !f_hs) begin
                checks++;
                if ((fhs_fall < 0 && n != 2) || (fhs_fall >= 0 && n - fhs_fall != HT)) begin
                    errors++; $display("FAIL hs_period n=%0d prev=%0d exp_period=800", n, fhs_fall);
                end
                fhs_fall = n;
            end
            if (!p_fhs && f_hs) begin
                checks++;
                if (n - fhs_fall != HS_W) begin
                    errors++; $display("FAIL hs_low got=%0d exp=96", n - fhs_fall);
                end
            end
            if (p_fvs && !f_vs) fvs_fall = n;
            if (!p_fvs && f_vs) begin
                checks++;
                if (fvs_fall != 2 || n - fvs_fall != 1600) begin
                    errors++; $display("FAIL vs_low_f fall=%0d rise=%0d exp_low=1600", fvs_fall, n);
                end
            end
            // Short core: frame period, VS width and visible pixel count per frame.
            if (p_svs && !s_vs) begin
                if (svs_fall >= 0) begin
                    checks++;
                    if (n - svs_fall != S_FRAME) begin
                        errors++; $display("FAIL vs_period_s got=%0d exp=%0d", n - svs_fall, S_FRAME);
                    end
                    checks++;
                    if (sbl_count != HV * S_VV) begin
                        errors++; $display("FAIL blank_count_s got=%0d exp=%0d", sbl_count, HV * S_VV);
                    end
                end
                svs_fall = n;
                sbl_count = 0;
            end
            if (!p_svs && s_vs) begin
                checks++;
                if (n - svs_fall != 1600) begin
                    errors++; $display("FAIL vs_low_s got=%0d exp=1600", n - svs_fall);
                end
            end
            if (!p_sbl && s_blank) begin
                sbl_rise = n;
                checks++;
                if (n % HT != H_START + 2) begin
                    errors++; $display("FAIL blank_start_s col=%0d exp=146", n % HT);
                end
            end
            if (p_sbl && !s_blank) begin
                checks++;
                if (n - sbl_rise != HV) begin
                    errors++; $display("FAIL blank_run_s got=%0d exp=640", n - sbl_rise);
                end
            end
            if (s_blank) sbl_count++;
            p_fhs = f_hs; p_fvs = f_vs; p_svs = s_vs; p_sbl = s_blank;
        end
    endtask

    task automatic test_addr_full();
        while (n < F_VSTART * HT + H_START) tick(8'd0);
        checks++;
        if (f_addr !== 19'd0 || f_blank !== 1'b0) begin
            errors++; $display("FAIL addr_first got=%0d blank=%b exp=0/0", f_addr, f_blank);
        end
        tick(8'd0);
        checks++;
        if (f_addr !== 19'd1) begin
            errors++; $display("FAIL addr_second got=%0d exp=1", f_addr);
        end
        tick(8'd0);
        checks++;
        if (f_blank !== 1'b1) begin
            errors++; $display("FAIL blank_first got=%b exp=1", f_blank);
        end
        while (n < F_VSTART * HT + 783) tick(8'd0);
        checks++;
        if (f_addr !== 19'd639) begin
            errors++; $display("FAIL addr_line_end got=%0d exp=639", f_addr);
        end
        while (n < (F_VSTART + 1) * HT + H_START) tick(8'd0);
        checks++;
        if (f_addr !== 19'd640) begin
            errors++; $display("FAIL addr_line2 got=%0d exp=640", f_addr);
        end
    endtask

    task automatic test_color_constant();
        int start;
        start = n;
        while (n < (F_VSTART + 3) * HT) begin
            tick(8'd1);
            if (n >= start + 2) begin
                checks++;
                if ({f_r, f_g, f_b} !== (f_blank ? 24'h00FF00 : 24'h0)) begin
                    errors++; $display("FAIL snake_rgb n=%0d got=%06h blank=%b", n, {f_r, f_g, f_b}, f_blank);
                end
                checks++;
                if (f_blank !== m_blank(n - 2, F_VT, F_VSTART, F_VV)) begin
                    errors++; $display("FAIL snake_blank n=%0d got=%b", n, f_blank);
                end
            end
        end
    endtask

    task automatic test_color_step();
        logic [7:0]  seq  [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd7};
        logic [23:0] expv [6] = '{24'h000000, 24'h00FF00, 24'hFF0000, 24'hFF4040, 24'h202020, 24'h000000};
        int base;
        int j;
        base = (F_VSTART + 3) * HT + 150;
        while (n < base) tick(8'd4);
        for (int k = 0; k < 8; k++) begin
            tick((k < 6) ? seq[k] : 8'd4);
            j = n - 2 - base;
            if (j == -1) begin
                checks++;
                if ({f_r, f_g, f_b} !== 24'h202020) begin
                    errors++; $display("FAIL step_pre got=%06h exp=202020", {f_r, f_g, f_b});
                end
            end else if (j >= 0 && j < 6) begin
                checks++;
                if ({f_r, f_g, f_b} !== expv[j]) begin
                    errors++; $display("FAIL step_%0d got=%06h exp=%06h", j, {f_r, f_g, f_b}, expv[j]);
                end
            end
        end
    endtask

    task automatic test_random_line();
        while (n < 40 * HT + 300) begin
            tick((n >= 40 * HT + 297) ? 8'd2 : rand_ci());
            checks++;
            if ({f_hs, f_vs, f_blank, f_r, f_g, f_b} !==
                {e_sync(n, F_VT, F_VSTART, F_VV), e_rgb(n, F_VT, F_VSTART, F_VV)}) begin
                errors++; $display("FAIL rand_f n=%0d got=%b/%06h exp=%b/%06h", n, {f_hs, f_vs, f_blank},
                                   {f_r, f_g, f_b}, e_sync(n, F_VT, F_VSTART, F_VV), e_rgb(n, F_VT, F_VSTART, F_VV));
            end
            checks++;
            if (f_addr !== 19'(m_addr(n, F_VT, F_VSTART, F_VV))) begin
                errors++; $display("FAIL rand_addr n=%0d got=%0d exp=%0d", n, f_addr, m_addr(n, F_VT, F_VSTART, F_VV));
            end
        end
    endtask

    task automatic test_reset_midline();
        int fall;
        int rise;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({f_hs, f_vs, f_blank} !== 3'b110 || f_addr !== 19'd0 || {f_r, f_g, f_b} !== 24'h0) begin
            errors++; $display("FAIL async_reset_f sync=%b addr=%0d rgb=%06h", {f_hs, f_vs, f_blank}, f_addr, {f_r, f_g, f_b});
        end
        checks++;
        if ({s_hs, s_vs, s_blank} !== 3'b110 || s_addr !== 19'd0) begin
            errors++; $display("FAIL async_reset_s sync=%b addr=%0d", {s_hs, s_vs, s_blank}, s_addr);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        n = 0;
        fall = -1;
        rise = -1;
        while (n < 200 && rise < 0) begin
            tick(8'd0);
            if (fall < 0 && !f_hs) fall = n;
            if (fall >= 0 && f_hs) rise = n;
        end
        checks++;
        if (fall != 2) begin
            errors++; $display("FAIL restart_hs_fall got=%0d exp=2", fall);
        end
        checks++;
        if (rise < 0 || rise - fall != HS_W) begin
            errors++; $display("FAIL restart_hs_low got=%0d exp=96", rise - fall);
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_addr_full();
        test_color_constant();
        test_color_step();
        test_random_line();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_video_core.md
Name: vga_video_core

Overview:
- 640x480@60 Hz VGA timing core for the snake display path.
- Generates HSYNC, VSYNC and BLANK, plus a linear pixel address (0..307199) for the game-drawing logic.
- Converts the 8-bit colour index returned by that logic into 24-bit RGB through a fixed palette.
- Sits between the game renderer and the VGA DAC pins. Syncs are delayed so they stay aligned with the RGB pipeline.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_SYNC, 96, horizontal sync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync pulse width in lines
- V_BACK, 33, vertical back porch in lines

Ports:
- iVGA_CLK  in  1  pixel clock (~25.175 MHz), all logic on rising edge
- iRST_n  in  1  asynchronous active-low reset
- color_index  in  8  palette index for the pixel currently addressed by oADDR
- oADDR  out  19  linear address of the current visible pixel (row*640+col)
- oHS  out  1  horizontal sync, active low
- oVS  out  1  vertical sync, active low
- oBLANK_n  out  1  high during the active video window
- r_data  out  8  red channel
- g_data  out  8  green channel
- b_data  out  8  blue channel

Behaviour:
- Reset: iRST_n is asynchronous and active-low; the clock is iVGA_CLK. While reset is asserted:
  - h_cnt=0, v_cnt=0, oADDR=0
  - oHS=1, oVS=1, oBLANK_n=0
  - r/g/b = 0; all delay stages cleared to these same values.
- Horizontal counter: h_cnt runs 0..799 and wraps to 0.
  - raw HS = 0 for h_cnt 0..95.
  - h_active for h_cnt 144..783.
- Vertical counter: v_cnt increments when h_cnt wraps and runs 0..524, wrapping to 0.
  - raw VS = 0 for v_cnt 0..1.
  - v_active for v_cnt 35..514.
- raw BLANK_n = h_active AND v_active.
- Address generator, on each clock:
  - rawHS=0 and rawVS=0 → oADDR <= 0.
  - else if raw BLANK_n=1 → oADDR <= oADDR+1.
  - otherwise hold.
  - Effect: while the k-th visible pixel of a frame is current, oADDR = k. After the last pixel, oADDR holds 307200 until the next vsync.
- Colour pipeline (2 cycles): stage 1 registers color_index; stage 2 registers the palette lookup of the stage-1 value onto r/g/b.
  - r/g/b are forced to 0 when the BLANK_n value aligned with stage 2 is 0.
- Sync alignment: raw HS/VS/BLANK_n pass through a 2-stage register delay, so oHS/oVS/oBLANK_n line up with the r/g/b of the index sampled in the same cycle.
- Palette (index → R,G,B):
  - 0 → 00,00,00 (board boundary)
  - 1 → 00,FF,00 (snake)
  - 2 → FF,00,00 (game-over screen)
  - 3 → FF,40,40 (apple)
  - 4 → 20,20,20 (background)
  - 5..255 → 00,00,00
- Reset mid-frame: everything returns to the reset values immediately (asynchronous). After release, timing restarts at h_cnt=0, v_cnt=0; the first raw sync is asserted on the first clock.

Decomposition:
- Shared package vga_pkg:
  - the eight timing constants
  - H_TOTAL=800, V_TOTAL=525
  - FRAME_PIXELS=307200
  - palette index constants IDX_BOUNDARY=0, IDX_SNAKE=1, IDX_GAMEOVER=2, IDX_APPLE=3, IDX_BG=4
- One sub-module, vga_sync_timer: the h/v counters producing raw HS, VS and BLANK_n.
- The palette case table and address counter stay in the top level.

Test Plan:
- Reset, then free-run one frame → oHS period exactly 800 clocks, low for 96; oVS period 420000 clocks, low for 1600 clocks (2 lines).
- Count oBLANK_n=1 cycles over one frame → exactly 307200: 640 per line on 480 consecutive lines, first active at h_cnt=144 + 2-cycle delay.
- Sample oADDR on the first active clock → 0; on the last active pixel → 307199; during blank after the frame → 307200; back to 0 during the next vsync+hsync overlap.
- Drive color_index=1 constantly during active video → r/g/b = 00/FF/00 exactly while oBLANK_n=1, and 0 while it is 0.
- Step color_index 0,1,2,3,4,7 on consecutive active clocks → RGB sequence 000000, 00FF00, FF0000, FF4040, 202020, 000000, each appearing 2 clocks after its index.
- Assert iRST_n=0 mid-line (h_cnt≈300, v_cnt≈200) → outputs go to reset values without waiting for a clock edge. After release, the first oHS low pulse occurs 2 clocks later and lasts 96 clocks.
